// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot-time instruction memory loader. It takes a byte stream over a
// valid/ready handshake and packs the bytes into little-endian 32-bit words.
// It writes the words one after another into the instruction memory's write
// port, starting at address 0. The core is held in stall until the whole
// image has been written.
//
// Optional feature (compile-time macro IMEM_LOAD_CHECKSUM_EN):
//   When IMEM_LOAD_CHECKSUM_EN is defined, one trailing XOR checksum byte
//   must follow the image. If that byte differs from the XOR of all image
//   bytes, load_err is raised.
//   When the macro is undefined, there is no CHECK state and no checksum
//   logic, and load_err is tied to 0.
//
// Ports:
//   clk         sole clock, rising edge
//   reset       synchronous, active-high
//   start       single-cycle request to begin loading (honoured in IDLE/DONE)
//   byte_valid  byte_data holds a valid byte
//   byte_data   image byte
//   byte_ready  loader accepts a byte this cycle (LOAD / CHECK)
//   imem_we     one-cycle write strobe to instruction memory
//   imem_waddr  write word address
//   imem_wdata  write word
//   cpu_stall   core must not fetch; high in every state except DONE
//   done        image fully written; held until next start or reset
//   load_err    checksum mismatch; level, held until next start or reset
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_stall,
  output logic              done,
  output logic              load_err
);

  localparam int BYTES  = DATA_W / 8;
  localparam int BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  // One extra bit so the word counter can hold DEPTH itself.
  localparam int CNT_W  = ADDR_W + 1;

  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES - 1);
  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  WORD_MAX  = CNT_W'(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
`ifdef IMEM_LOAD_CHECKSUM_EN
  localparam logic [1:0] ST_CHECK = 2'd2;
`endif
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]        state_reg;
  logic [1:0]        state_next;
  logic [BCNT_W-1:0] byte_cnt_reg;
  logic [CNT_W-1:0]  word_cnt_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] waddr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-9:0] lane_bus;     // bytes 0..BYTES-2 of the word in progress

  logic accept;
  logic load_accept;
  logic word_last_byte;
  logic image_last_byte;
  logic start_ok;

  // Handshake and event decode.
  assign byte_ready      = (state_reg == ST_LOAD)
`ifdef IMEM_LOAD_CHECKSUM_EN
                         || (state_reg == ST_CHECK)
`endif
                         ;
  assign accept          = byte_valid && byte_ready;
  assign load_accept     = accept && (state_reg == ST_LOAD);
  assign word_last_byte  = load_accept && (byte_cnt_reg == LAST_BYTE);
  assign image_last_byte = word_last_byte && (word_cnt_reg == LAST_WORD);
  // A start request is ignored while a load or check is in progress.
  assign start_ok        = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        if (image_last_byte) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
          state_next = ST_CHECK;
`else
          state_next = ST_DONE;
`endif
        end
      end
`ifdef IMEM_LOAD_CHECKSUM_EN
      ST_CHECK: begin
        if (accept) state_next = ST_DONE;
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Byte and word counters. The word counter saturates at DEPTH, so the
  // write address never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt_reg <= '0;
      word_cnt_reg <= '0;
    end else if (start_ok) begin
      byte_cnt_reg <= '0;
      word_cnt_reg <= '0;
    end else if (load_accept) begin
      if (word_last_byte) begin
        byte_cnt_reg <= '0;
        if (word_cnt_reg != WORD_MAX) word_cnt_reg <= word_cnt_reg + 1'b1;
      end else begin
        byte_cnt_reg <= byte_cnt_reg + 1'b1;
      end
    end
  end

  // Byte lanes of the word in progress (little-endian: byte k -> [8k+7:8k]).
  // The top byte is never stored here; it is written straight into the
  // output word together with the stored lanes.
  genvar gi;
  generate
    for (gi = 0; gi < BYTES - 1; gi++) begin : g_lane
      logic [7:0] lane_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          lane_reg <= '0;
        end else if (load_accept && (byte_cnt_reg == BCNT_W'(gi))) begin
          lane_reg <= byte_data;
        end
      end
      assign lane_bus[gi*8 +: 8] = lane_reg;
    end
  endgenerate

  // Write port registers: the strobe fires the cycle after the last byte of
  // a word is accepted. Address and data stay put until the next word.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_reg    <= 1'b0;
      waddr_reg <= '0;
      wdata_reg <= '0;
    end else begin
      we_reg <= word_last_byte;
      if (word_last_byte) begin
        waddr_reg <= word_cnt_reg[ADDR_W-1:0];
        wdata_reg <= {byte_data, lane_bus};
      end
    end
  end

  assign imem_we    = we_reg;
  assign imem_waddr = waddr_reg;
  assign imem_wdata = wdata_reg;
  assign cpu_stall  = (state_reg != ST_DONE);
  assign done       = (state_reg == ST_DONE);

`ifdef IMEM_LOAD_CHECKSUM_EN
  // Running XOR of the image bytes, compared with the single trailing byte.
  logic [7:0] csum_reg;
  logic       err_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      csum_reg <= '0;
      err_reg  <= 1'b0;
    end else if (start_ok) begin
      csum_reg <= '0;
      err_reg  <= 1'b0;
    end else if (load_accept) begin
      csum_reg <= csum_reg ^ byte_data;
    end else if (accept && (state_reg == ST_CHECK)) begin
      err_reg <= (byte_data != csum_reg);
    end
  end

  assign load_err = err_reg;
`else
  assign load_err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Self-checking bench for imem_loader. For each image, the stimulus side
// works out which bytes are accepted. For every completed word it pushes the
// expected {address, word} onto a queue. The word is assembled from the image
// array by plain byte arithmetic. A separate monitor pops one entry from the
// queue for every imem_we strobe and compares it with the DUT output.
// Define IMEM_LOAD_CHECKSUM_EN for both the bench and the DUT to exercise the
// checksum build.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 16;
  localparam int NB     = 4 * DEPTH;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [DATA_W-1:0] imem_wdata;
  logic              cpu_stall;
  logic              done;
  logic              load_err;

  imem_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_stall  (cpu_stall),
    .done       (done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  img [NB];
  logic [63:0] exp_q [$];   // {address, word}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference word: little-endian packing of four image bytes.
  function automatic logic [31:0] word_of(input int w);
    return {img[4*w+3], img[4*w+2], img[4*w+1], img[4*w]};
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, byte_ready, 0);
    check({tag, "_we"},    imem_we,    0);
    check({tag, "_waddr"}, imem_waddr, 0);
    check({tag, "_wdata"}, imem_wdata, 0);
    check({tag, "_stall"}, cpu_stall,  1);
    check({tag, "_done"},  done,       0);
    check({tag, "_err"},   load_err,   0);
  endtask

  // Offers byte_valid=1 for a few cycles while the loader is not accepting.
  task automatic offer_while_idle(input string tag, input logic exp_done);
    for (int i = 0; i < 4; i++) begin
      byte_valid = 1'b1;
      byte_data  = 8'($urandom);
      check({tag, "_ready"}, byte_ready, 0);
      check({tag, "_done"},  done, exp_done);
      @(negedge clk);
    end
    byte_valid = 1'b0;
  endtask

  // Runs one image. gap_mode: 0 = valid every cycle, 1 = every other cycle,
  // 2 = random. abort_after >= 0 asserts reset once that many bytes are in.
  task automatic run_image(input int gap_mode, input bit poke_start,
                           input int abort_after, input bit bad_csum);
    int         k = 0;
    int         cyc = 0;
    bit         give;
    logic [7:0] x = 8'h00;
    logic [7:0] csum;
    @(negedge clk);
    start      = 1'b1;
    byte_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("ready_after_start", byte_ready, 1);
    check("done_cleared",      done,       0);
    check("err_cleared",       load_err,   0);
    while (k < NB) begin
      if (cyc >= 1000) begin
        n_cmp++;
        n_err++;
        $display("FAIL load_timeout: got %0d bytes, expected %0d", k, NB);
        byte_valid = 1'b0;
        return;
      end
      case (gap_mode)
        0:       give = 1'b1;
        1:       give = (cyc % 2 == 0);
        default: give = 1'($urandom_range(0, 1));
      endcase
      byte_valid = give;
      byte_data  = give ? img[k] : 8'($urandom);
      // Stray start pulses during LOAD must have no effect.
      start = poke_start && ($urandom_range(0, 5) == 0);
      check("ready_in_load", byte_ready, 1);
      check("stall_in_load", cpu_stall,  1);
      if (give) begin
        x = x ^ img[k];
        if (k % 4 == 3) exp_q.push_back({32'(k / 4), word_of(k / 4)});
        k++;
      end
      @(negedge clk);
      cyc++;
      if (abort_after >= 0 && k == abort_after) begin
        byte_valid = 1'b0;
        start      = 1'b0;
        reset      = 1'b1;
        @(negedge clk);
        check_reset_vals("abort");
        reset = 1'b0;
        $display("image aborted after %0d bytes", k);
        return;
      end
    end
    byte_valid = 1'b0;
    start      = 1'b0;
    csum       = bad_csum ? 8'h5A : x;
`ifdef IMEM_LOAD_CHECKSUM_EN
    check("ready_in_check", byte_ready, 1);
    check("busy_in_check",  done,       0);
    byte_valid = 1'b1;
    byte_data  = csum;
    @(negedge clk);
    byte_valid = 1'b0;
    check("load_err", load_err, (csum != x));
`else
    check("load_err_tied", load_err, 0);
`endif
    check("done",           done,       1);
    check("stall_released", cpu_stall,  0);
    check("ready_dropped",  byte_ready, 0);
    $display("image complete mode=%0d xor=0x%02h csum_sent=0x%02h", gap_mode, x, csum);
  endtask

  // Monitor: every write strobe must match the oldest expected word.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (imem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: got addr=%0d data=0x%08h, expected no write",
                   imem_waddr, imem_wdata);
        end else begin
          e = exp_q.pop_front();
          $display("write addr=%0d data=0x%08h", imem_waddr, imem_wdata);
          check("waddr", 64'(imem_waddr), 64'(e[63:32]));
          check("wdata", 64'(imem_wdata), 64'(e[31:0]));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);

    offer_while_idle("idle", 1'b0);

    for (int i = 0; i < NB; i++) img[i] = 8'(i);
    run_image(0, 1'b0, -1, 1'b0);           // ramp, every cycle
    offer_while_idle("done_hold", 1'b1);
    run_image(1, 1'b0, -1, 1'b0);           // restart from DONE, toggling valid
    run_image(0, 1'b0, -1, 1'b1);           // wrong checksum byte 0x5A
    run_image(2, 1'b0, 10, 1'b0);           // reset after 10 bytes
    check("queue_after_abort", 64'(exp_q.size()), 0);
    run_image(0, 1'b0, -1, 1'b0);           // fresh load restarts at address 0

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NB; i++) img[i] = 8'($urandom);
      run_image(2, 1'b1, -1, 1'(r % 2));
    end

    repeat (4) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
